gp_maxpool_core: RTL and testbench

GP_MAXPOOL_CORE -- requirements
Module: gp_maxpool_core

---
 rtl/gp_axis_pkg.sv | 21 ++
 rtl/gp_pool_max_acc.sv | 31 +++
 rtl/gp_maxpool_core.sv | 126 ++++++++++++
 tb/tb_gp_maxpool_core.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gp_axis_pkg.sv
// Shared defaults, FSM state encoding and small helpers for the max-pool core.
// Used by the core and by its running-max accumulator.
package gp_axis_pkg;

    localparam int unsigned DATA_WIDTH_DEF   = 32;
    localparam int unsigned IN_DATA_NUM_DEF  = 8;
    localparam int unsigned OUT_DATA_NUM_DEF = 4;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRead   = 2'd1,
        StDrain  = 2'd2,
        StFinish = 2'd3
    } state_e;

    // Address width that stays legal (>= 1 bit) for single-entry buffers.
    function automatic int unsigned addr_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gp_pool_max_acc.sv
// Running signed-maximum register for one pooling group.
// load restarts the group with din; otherwise din replaces max only if strictly greater.
module gp_pool_max_acc
    import gp_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] max
);

    logic [DATA_WIDTH-1:0] max_q;
    logic                  greater;

    assign greater = $signed(din) > $signed(max_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_q <= '0;
        end else if (en && (load || greater)) begin
            max_q <= din;
        end
    end

    assign max = max_q;

endmodule

// File: rtl/gp_maxpool_core.sv
// 1-D signed max-pool engine: streams IN_DATA_NUM words from the input buffer and
// writes OUT_DATA_NUM group maxima to the output buffer, one job per start edge.
module gp_maxpool_core
    import gp_axis_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int unsigned IN_DATA_NUM  = IN_DATA_NUM_DEF,
    parameter int unsigned OUT_DATA_NUM = OUT_DATA_NUM_DEF,
    localparam int unsigned IN_AW       = addr_width(IN_DATA_NUM),
    localparam int unsigned OUT_AW      = addr_width(OUT_DATA_NUM)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  axisif_start,
    output logic                  axisif_done,
    output logic [IN_AW-1:0]      axisif_bufferIn_adr,
    input  logic [DATA_WIDTH-1:0] axisif_bufferIn_data,
    output logic [OUT_AW-1:0]     axisif_bufferOut_adr,
    output logic [DATA_WIDTH-1:0] axisif_bufferOut_data,
    output logic                  axisif_bufferOut_wr
);

    localparam int unsigned POOL = IN_DATA_NUM / OUT_DATA_NUM;
    localparam int unsigned PW   = addr_width(POOL);

    localparam logic [IN_AW-1:0]  IN_LAST   = IN_AW'(IN_DATA_NUM - 1);
    localparam logic [OUT_AW-1:0] OUT_LAST  = OUT_AW'(OUT_DATA_NUM - 1);
    localparam logic [PW-1:0]     POOL_LAST = PW'(POOL - 1);

    if ((IN_DATA_NUM % OUT_DATA_NUM) != 0) begin : g_bad_ratio
        $error("gp_maxpool_core: IN_DATA_NUM must be a multiple of OUT_DATA_NUM");
    end

    state_e                state_q, state_d;
    logic                  start_q;
    logic                  done_q;
    logic [IN_AW-1:0]      in_adr_q;
    logic                  rd_vld_q;
    logic [PW-1:0]         pos_q;
    logic [OUT_AW-1:0]     grp_q;
    logic                  wr_q;
    logic [OUT_AW-1:0]     out_adr_q;
    logic [DATA_WIDTH-1:0] out_data_q;

    logic                  launch;
    logic                  capture;
    logic                  first;
    logic                  last;
    logic [DATA_WIDTH-1:0] acc_max;
    logic [DATA_WIDTH-1:0] grp_max;

    // Data for the address issued last cycle is on the bus this cycle.
    assign capture = rd_vld_q;
    assign first   = (pos_q == '0);
    assign last    = (pos_q == POOL_LAST);
    assign grp_max = (first || ($signed(axisif_bufferIn_data) > $signed(acc_max))) ?
                     axisif_bufferIn_data : acc_max;

    gp_pool_max_acc #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_acc (
        .clk  (clk),
        .rst  (rst),
        .load (capture && first),
        .en   (capture),
        .din  (axisif_bufferIn_data),
        .max  (acc_max)
    );

    always_comb begin
        launch  = (state_q == StIdle) && axisif_start && !start_q;
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (launch) state_d = StRead;
            StRead:   if (in_adr_q == IN_LAST) state_d = StDrain;
            StDrain:  if (wr_q && (out_adr_q == OUT_LAST)) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            start_q    <= 1'b0;
            done_q     <= 1'b1;
            in_adr_q   <= '0;
            rd_vld_q   <= 1'b0;
            pos_q      <= '0;
            grp_q      <= '0;
            wr_q       <= 1'b0;
            out_adr_q  <= '0;
            out_data_q <= '0;
        end else begin
            state_q  <= state_d;
            start_q  <= axisif_start;
            done_q   <= (state_d == StIdle);
            rd_vld_q <= (state_q == StRead);
            wr_q     <= 1'b0;

            if (state_q == StRead) begin
                in_adr_q <= (in_adr_q == IN_LAST) ? '0 : in_adr_q + IN_AW'(1);
            end

            if (launch) begin
                pos_q <= '0;
                grp_q <= '0;
            end else if (capture) begin
                pos_q <= last ? '0 : pos_q + PW'(1);
                if (last) begin
                    wr_q       <= 1'b1;
                    out_adr_q  <= grp_q;
                    out_data_q <= grp_max;
                    grp_q      <= grp_q + OUT_AW'(1);
                end
            end
        end
    end

    assign axisif_done           = done_q;
    assign axisif_bufferIn_adr   = in_adr_q;
    assign axisif_bufferOut_adr  = out_adr_q;
    assign axisif_bufferOut_data = out_data_q;
    assign axisif_bufferOut_wr   = wr_q;

endmodule

// File: tb/tb_gp_maxpool_core.sv
// Self-checking bench for gp_maxpool_core: an 8->4 instance and a 4->4 (pass-through) instance,
// table vectors, randomized jobs against a max-of-group model, and start/reset corner sequences.
module tb_gp_maxpool_core;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        start_a, done_a, wr_a;
    logic [2:0]  in_adr_a;
    logic [1:0]  out_adr_a;
    logic [31:0] din_a, out_data_a;

    logic        start_b, done_b, wr_b;
    logic [1:0]  in_adr_b;
    logic [1:0]  out_adr_b;
    logic [31:0] din_b, out_data_b;

    logic [31:0] mem_a [8];
    logic [31:0] mem_b [4];

    gp_maxpool_core #(
        .DATA_WIDTH   (32),
        .IN_DATA_NUM  (8),
        .OUT_DATA_NUM (4)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .axisif_start          (start_a),
        .axisif_done           (done_a),
        .axisif_bufferIn_adr   (in_adr_a),
        .axisif_bufferIn_data  (din_a),
        .axisif_bufferOut_adr  (out_adr_a),
        .axisif_bufferOut_data (out_data_a),
        .axisif_bufferOut_wr   (wr_a)
    );

    gp_maxpool_core #(
        .DATA_WIDTH   (32),
        .IN_DATA_NUM  (4),
        .OUT_DATA_NUM (4)
    ) dut_p1 (
        .clk                   (clk),
        .rst                   (rst),
        .axisif_start          (start_b),
        .axisif_done           (done_b),
        .axisif_bufferIn_adr   (in_adr_b),
        .axisif_bufferIn_data  (din_b),
        .axisif_bufferOut_adr  (out_adr_b),
        .axisif_bufferOut_data (out_data_b),
        .axisif_bufferOut_wr   (wr_b)
    );

    // Synchronous-read input buffers: data one cycle after the address.
    always @(posedge clk) begin
        din_a <= mem_a[in_adr_a];
        din_b <= mem_b[in_adr_b];
    end

    int pc = 0;
    int p0 = 0;
    always @(posedge clk) pc <= pc + 1;

    typedef struct {
        int          dut;
        int          adr;
        logic [31:0] data;
        int          n;
    } wr_t;
    wr_t wq[$];

    always @(negedge clk) begin
        if (wr_a) wq.push_back('{0, int'(out_adr_a), out_data_a, pc - p0});
        if (wr_b) wq.push_back('{1, int'(out_adr_b), out_data_b, pc - p0});
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_start(input int sel, input logic v);
        if (sel != 0) start_b = v;
        else start_a = v;
    endtask

    function automatic logic [31:0] ref_max(input int sel, input int k);
        int pool;
        logic signed [31:0] m, x;
        pool = (sel != 0) ? 1 : 2;
        m = (sel != 0) ? mem_b[k * pool] : mem_a[k * pool];
        for (int j = 1; j < pool; j++) begin
            x = (sel != 0) ? mem_b[k * pool + j] : mem_a[k * pool + j];
            if (x > m) m = x;
        end
        return m;
    endfunction

    // One job: start edge, optional held start or extra start edge while busy, then
    // check done-low duration and every write (address, data, cycle after launch).
    task automatic run_job(input int sel, input logic [31:0] exp [4], input int hold,
                           input int busy_at, input string tag);
        int    low;
        int    in_num;
        int    pool;
        int    n;
        logic  d;
        low    = 0;
        in_num = (sel != 0) ? 4 : 8;
        pool   = (sel != 0) ? 1 : 2;
        wq.delete();
        @(negedge clk);
        set_start(sel, 1'b1);
        @(posedge clk);
        #1 p0 = pc;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            n = pc - p0;
            d = (sel != 0) ? done_b : done_a;
            if (!d) low++;
            if (hold > 0) set_start(sel, n < hold - 1);
            else set_start(sel, (busy_at > 0) && (n == busy_at - 1));
        end
        set_start(sel, 1'b0);
        chk({tag, " done-low cycles"}, low, in_num + 3);
        chk({tag, " write count"}, wq.size(), 4);
        for (int k = 0; k < wq.size() && k < 4; k++) begin
            chk($sformatf("%s w%0d dut", tag, k), wq[k].dut, sel);
            chk($sformatf("%s w%0d adr", tag, k), wq[k].adr, k);
            chk($sformatf("%s w%0d data", tag, k), wq[k].data, exp[k]);
            chk($sformatf("%s w%0d cycle", tag, k), wq[k].n, pool * (k + 1) + 1);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] in  [8];
        logic [31:0] exp [4];
    } vec_t;
    vec_t vt [3];

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [31:0] e [4];
        int          cnt;

        vt[0].name = "basic";
        vt[0].in   = '{32'd3, 32'hFFFF_FFFF, 32'd7, 32'd7, 32'hFFFF_FFFB, 32'hFFFF_FFFE,
                       32'd0, 32'h7FFF_FFFF};
        vt[0].exp  = '{32'd3, 32'd7, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
        vt[1].name = "allneg";
        vt[1].in   = '{8{32'h8000_0000}};
        vt[1].exp  = '{4{32'h8000_0000}};
        vt[2].name = "mixed";
        vt[2].in   = '{32'hFFFF_FFFD, 32'hFFFF_FFF9, 32'd5, 32'hFFFF_FFFB, 32'h8000_0000,
                       32'hFFFF_FFFF, 32'd100, 32'd99};
        vt[2].exp  = '{32'hFFFF_FFFD, 32'd5, 32'hFFFF_FFFF, 32'd100};

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 8; i++) mem_a[i] = '0;
        for (int i = 0; i < 4; i++) mem_b[i] = '0;
        repeat (3) @(negedge clk);
        chk("reset done", done_a, 1'b1);
        chk("reset wr", wr_a, 1'b0);
        chk("reset in_adr", in_adr_a, 3'd0);
        chk("reset out_adr", out_adr_a, 2'd0);
        chk("reset out_data", out_data_a, 32'd0);
        chk("reset p1 done", done_b, 1'b1);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 3; v++) begin
            for (int i = 0; i < 8; i++) mem_a[i] = vt[v].in[i];
            run_job(0, vt[v].exp, 0, 0, vt[v].name);
        end

        for (int i = 0; i < 8; i++) mem_a[i] = vt[0].in[i];
        run_job(0, vt[0].exp, 40, 0, "held");

        for (int i = 0; i < 8; i++) mem_a[i] = vt[2].in[i];
        run_job(0, vt[2].exp, 0, 3, "busy");

        // Reset while address 5 is on the bus: groups 0 and 1 are already written.
        for (int i = 0; i < 8; i++) mem_a[i] = vt[0].in[i];
        wq.delete();
        @(negedge clk);
        start_a = 1'b1;
        @(posedge clk);
        #1 p0 = pc;
        @(negedge clk);
        start_a = 1'b0;
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("abort wr", wr_a, 1'b0);
        chk("abort done", done_a, 1'b1);
        chk("abort in_adr", in_adr_a, 3'd0);
        chk("abort out_data", out_data_a, 32'd0);
        cnt = wq.size();
        chk("abort pre-reset writes", cnt, 2);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (15) @(negedge clk);
        chk("abort no late writes", wq.size(), cnt);
        chk("abort idle done", done_a, 1'b1);
        run_job(0, vt[0].exp, 0, 0, "after-reset");

        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 8; i++) begin
                case ($urandom_range(0, 3))
                    0:       mem_a[i] = 32'h8000_0000;
                    1:       mem_a[i] = 32'h7FFF_FFFF;
                    2:       mem_a[i] = $urandom_range(0, 15) - 8;
                    default: mem_a[i] = $urandom;
                endcase
            end
            for (int k = 0; k < 4; k++) e[k] = ref_max(0, k);
            run_job(0, e, 0, 0, $sformatf("rand%0d", r));
        end

        mem_b = '{32'd9, 32'd8, 32'd7, 32'd6};
        e     = '{32'd9, 32'd8, 32'd7, 32'd6};
        run_job(1, e, 0, 0, "pool1");
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) mem_b[i] = $urandom;
            for (int k = 0; k < 4; k++) e[k] = ref_max(1, k);
            run_job(1, e, 0, 0, $sformatf("pool1rand%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
